// File: rtl/usb_pkg.sv
// Shared encodings for the low-level USB transmitter: FSM states, line states, framing constants.
package usb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StStuffTail,
    StEopSe0,
    StEopJ
  } state_e;

  typedef enum logic [1:0] {
    LineJ,
    LineK,
    LineSe0
  } line_e;

  localparam logic [7:0]  SyncByte    = 8'h80;
  localparam int unsigned StuffLen    = 6;
  localparam int unsigned EopSe0Bits  = 2;
  localparam int unsigned BitsPerByte = 8;

  // {dp, dm}; J polarity depends on the signalling speed.
  function automatic logic [1:0] line_enc(line_e line, logic fs);
    logic [1:0] j;
    j = fs ? 2'b10 : 2'b01;
    case (line)
      LineJ:   line_enc = j;
      LineK:   line_enc = ~j;
      default: line_enc = 2'b00;
    endcase
  endfunction

  function automatic line_e line_toggle(line_e line);
    return (line == LineJ) ? LineK : LineJ;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period divider: counts 0..div_last while enabled, flags the first and last clk of each bit.
module usb_bit_timer #(
  parameter int unsigned CntW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [CntW-1:0] div_last,
  output logic            bit_start,
  output logic            bit_end
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != div_last)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_start = en && (cnt_q == '0);
  assign bit_end   = en && (cnt_q == div_last);

endmodule

// File: rtl/usb_ll_tx.sv
// Low-level USB transmitter: SYNC, NRZI, bit stuffing and EOP onto the D+/D- pair.
// Define USB_TX_FULL_SPEED_EN to honour usb_speed; otherwise the link is low-speed only.
module usb_ll_tx
  import usb_pkg::*;
#(
  parameter int unsigned CLK_DIV_FS = 4,
  parameter int unsigned CLK_DIV_LS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_only_eop,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_bit_pulse,
  input  logic       usb_speed,
  output logic       usb_tx_dp,
  output logic       usb_tx_dm,
  output logic       usb_tx_oe,
  output logic       is_sof_eop
);

  localparam int unsigned DivMax = (CLK_DIV_LS > CLK_DIV_FS) ? CLK_DIV_LS : CLK_DIV_FS;
  localparam int unsigned CntW   = $clog2(DivMax + 1);

  state_e          state_q, state_d;
  line_e           line_q, line_d;
  logic            oe_q, oe_d;
  logic            speed_q, speed_d;
  logic            eop_only_q, eop_only_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      ones_q, ones_d;
  logic [1:0]      eop_cnt_q, eop_cnt_d;
  logic [CntW-1:0] div_last;
  logic            bit_start, bit_end;
  logic            speed_sel, speed_eff;
  logic            byte_done, stuff_due, next_bit;

`ifdef USB_TX_FULL_SPEED_EN
  assign speed_sel = usb_speed;
  assign div_last  = speed_q ? CntW'(CLK_DIV_FS - 1) : CntW'(CLK_DIV_LS - 1);
  // While idle the line follows the requested speed so J is correct before the packet starts.
  assign speed_eff = (state_q == StIdle) ? usb_speed : speed_q;
`else
  logic unused_speed;
  assign unused_speed = usb_speed | speed_q;
  assign speed_sel    = 1'b0;
  assign div_last     = CntW'(CLK_DIV_LS - 1);
  assign speed_eff    = 1'b0;
`endif

  usb_bit_timer #(
    .CntW(CntW)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (oe_q),
    .div_last (div_last),
    .bit_start(bit_start),
    .bit_end  (bit_end)
  );

  assign byte_done = (bit_cnt_q == 4'(BitsPerByte));
  assign stuff_due = (ones_q == 3'(StuffLen));
  assign next_bit  = byte_done ? tx_data[0] : shift_q[0];

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    oe_d       = oe_q;
    speed_d    = speed_q;
    eop_only_d = eop_only_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    ones_d     = ones_q;
    eop_cnt_d  = eop_cnt_q;
    tx_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          oe_d       = 1'b1;
          speed_d    = speed_sel;
          eop_only_d = tx_only_eop;
          eop_cnt_d  = '0;
          if (tx_only_eop) begin
            state_d = StEopSe0;
            line_d  = LineSe0;
          end else begin
            // First SYNC bit goes out together with oe.
            state_d   = StSync;
            line_d    = SyncByte[0] ? LineJ : LineK;
            ones_d    = {2'b00, SyncByte[0]};
            shift_d   = SyncByte >> 1;
            bit_cnt_d = 4'd1;
          end
        end
      end

      StSync, StData: begin
        if (bit_end) begin
          if (stuff_due) begin
            line_d = line_toggle(line_q);
            ones_d = '0;
            if (byte_done && !tx_valid) begin
              state_d = StStuffTail;
            end
          end else if (byte_done && !tx_valid) begin
            state_d   = StEopSe0;
            line_d    = LineSe0;
            eop_cnt_d = '0;
          end else begin
            if (byte_done) begin
              tx_ready  = 1'b1;
              shift_d   = tx_data >> 1;
              bit_cnt_d = 4'd1;
              state_d   = StData;
            end else begin
              shift_d   = shift_q >> 1;
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
            if (next_bit) begin
              ones_d = ones_q + 3'd1;
            end else begin
              line_d = line_toggle(line_q);
              ones_d = '0;
            end
          end
        end
      end

      StStuffTail: begin
        if (bit_end) begin
          state_d   = StEopSe0;
          line_d    = LineSe0;
          eop_cnt_d = '0;
        end
      end

      StEopSe0: begin
        if (bit_end) begin
          if (eop_cnt_q == 2'(EopSe0Bits - 1)) begin
            state_d = StEopJ;
            line_d  = LineJ;
          end else begin
            eop_cnt_d = eop_cnt_q + 2'd1;
          end
        end
      end

      StEopJ: begin
        if (bit_end) begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        oe_d    = 1'b0;
        line_d  = LineJ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      line_q     <= LineJ;
      oe_q       <= 1'b0;
      speed_q    <= 1'b0;
      eop_only_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      ones_q     <= '0;
      eop_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      oe_q       <= oe_d;
      speed_q    <= speed_d;
      eop_only_q <= eop_only_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_q     <= ones_d;
      eop_cnt_q  <= eop_cnt_d;
    end
  end

  assign usb_tx_oe    = oe_q;
  assign tx_bit_pulse = bit_start;
  assign is_sof_eop   = eop_only_q && ((state_q == StEopSe0) || (state_q == StEopJ));
  assign {usb_tx_dp, usb_tx_dm} = line_enc(line_q, speed_eff);

endmodule

// File: tb/tb_usb_ll_tx.sv
// Bench for usb_ll_tx: packet-level model of the expected line trace plus an NRZI decoder.
module tb_usb_ll_tx;

  logic       clk;
  logic       rst;
  logic       tx_only_eop;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_bit_pulse;
  logic       usb_speed;
  logic       usb_tx_dp;
  logic       usb_tx_dm;
  logic       usb_tx_oe;
  logic       is_sof_eop;

  usb_ll_tx dut (
    .clk         (clk),
    .rst         (rst),
    .tx_only_eop (tx_only_eop),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_bit_pulse(tx_bit_pulse),
    .usb_speed   (usb_speed),
    .usb_tx_dp   (usb_tx_dp),
    .usb_tx_dm   (usb_tx_dm),
    .usb_tx_oe   (usb_tx_oe),
    .is_sof_eop  (is_sof_eop)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

`ifdef USB_TX_FULL_SPEED_EN
  localparam bit FsSupported = 1'b1;
`else
  localparam bit FsSupported = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Expected per-clk outputs {oe, dp, dm, bit_pulse, ready, sof}.
  logic [5:0] exp_q[$];
  logic [7:0] pkt[16];
  bit         run = 0;
  bit         meas = 0;
  bit         rdy_seen = 0;
  bit         cur_fs = 0;
  bit         in_eop = 0;
  int         trace_i = 0;
  int         rdy_cnt, oe_cnt, pre_cnt, sof_cnt;
  bit         dec_lvls[$];

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  function automatic logic [1:0] jk(input bit lvl, input bit fs);
    logic [1:0] j;
    j = fs ? 2'b10 : 2'b01;
    return lvl ? j : ~j;
  endfunction

  // Builds the whole expected trace from the packet contents.
  task automatic build(input bit fs, input bit only, input int n);
    int         div;
    int         ones;
    bit         lvl;
    bit         wb[$];
    int         bstart[$];
    logic [7:0] b;
    logic [5:0] e;
    div = fs ? 4 : 32;
    exp_q.delete();
    if (!only) begin
      ones = 0;
      for (int k = -1; k < n; k++) begin
        b = (k < 0) ? 8'h80 : pkt[k];
        if (k >= 0) bstart.push_back(wb.size());
        for (int i = 0; i < 8; i++) begin
          wb.push_back(b[i]);
          ones = b[i] ? ones + 1 : 0;
          if (ones == 6) begin
            wb.push_back(1'b0);
            ones = 0;
          end
        end
      end
    end
    lvl = 1'b1;
    foreach (wb[j]) begin
      if (!wb[j]) lvl = !lvl;
      for (int c = 0; c < div; c++) exp_q.push_back({1'b1, jk(lvl, fs), c == 0, 1'b0, 1'b0});
    end
    foreach (bstart[k]) begin
      e = exp_q[bstart[k] * div - 1];
      e[1] = 1'b1;
      exp_q[bstart[k] * div - 1] = e;
    end
    for (int j = 0; j < 3; j++) begin
      for (int c = 0; c < div; c++) begin
        exp_q.push_back({1'b1, (j < 2) ? 2'b00 : jk(1'b1, fs), c == 0, 1'b0, only});
      end
    end
    exp_q.push_back({1'b0, jk(1'b1, fs), 3'b000});
  endtask

  // Single compare process plus per-packet statistics and line sampling.
  always @(negedge clk) begin
    logic [5:0] e;
    logic [5:0] got;
    if (run && exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = {usb_tx_oe, usb_tx_dp, usb_tx_dm, tx_bit_pulse, tx_ready, is_sof_eop};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL trace[%0d] oe/dp/dm/pulse/ready/sof: got %b required %b", trace_i, got, e);
      end
      trace_i++;
    end
    if (tx_ready) rdy_seen = 1;
    if (meas && usb_tx_oe) begin
      oe_cnt++;
      if (!usb_tx_dp && !usb_tx_dm) in_eop = 1;
      if (is_sof_eop) sof_cnt++;
      if (tx_ready) rdy_cnt++;
      if (tx_bit_pulse && !in_eop) begin
        pre_cnt++;
        dec_lvls.push_back(cur_fs ? usb_tx_dp : usb_tx_dm);
      end
    end
  end

  task automatic decode_check(input int n);
    bit         prev;
    bit         b;
    int         ones;
    bit         bits[$];
    logic [7:0] byt;
    prev = 1'b1;
    ones = 0;
    foreach (dec_lvls[i]) begin
      b    = (dec_lvls[i] == prev);
      prev = dec_lvls[i];
      if (ones == 6) begin
        ones = 0;
      end else begin
        bits.push_back(b);
        ones = b ? ones + 1 : 0;
      end
    end
    check("decoded_bit_count", bits.size(), 8 * (n + 1));
    for (int k = 0; k <= n && 8 * k + 7 < bits.size(); k++) begin
      for (int i = 0; i < 8; i++) byt[i] = bits[8 * k + i];
      if (k == 0) check("decoded_sync", int'(byt), 32'h80);
      else check($sformatf("decoded_byte%0d", k - 1), int'(byt), int'(pkt[k - 1]));
    end
  endtask

  task automatic run_pkt(input bit fs, input bit only, input int n, input int exp_len,
                         input int exp_rdy, input int exp_oe, input int exp_pre);
    bit         fs_eff;
    int         div;
    int         idx;
    int         guard;
    int         limit;
    logic [7:0] sync_dp;
    logic [7:0] sync_want;
    fs_eff = fs && FsSupported;
    div    = fs_eff ? 4 : 32;
    build(fs_eff, only, n);
    check("model_len", exp_q.size(), exp_len);
    if (!only) begin
      for (int c = 0; c < 8; c++) sync_dp[c] = exp_q[c * div][4];
      sync_want = fs_eff ? 8'h2A : 8'hD5;
      check("model_sync_dp", int'(sync_dp), int'(sync_want));
    end
    rdy_cnt = 0; oe_cnt = 0; pre_cnt = 0; sof_cnt = 0;
    in_eop = 0; rdy_seen = 0; trace_i = 0;
    dec_lvls.delete();
    cur_fs = fs_eff;
    limit  = exp_q.size() + 100;
    @(negedge clk);
    usb_speed   = fs;
    tx_only_eop = only;
    tx_data     = only ? 8'h00 : pkt[0];
    tx_valid    = 1'b1;
    idx         = 0;
    @(posedge clk);
    #1;
    run  = 1;
    meas = 1;
    if (only) tx_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < limit) begin
      @(posedge clk);
      #1;
      guard++;
      if (rdy_seen) begin
        rdy_seen = 0;
        idx++;
        if (idx < n) begin
          tx_data = pkt[idx];
        end else begin
          tx_valid = 1'b0;
          tx_data  = 8'hA5;
        end
      end
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d entries left required 0", exp_q.size());
    end
    run      = 0;
    meas     = 0;
    tx_valid = 1'b0;
    exp_q.delete();
    check("ready_pulses", rdy_cnt, exp_rdy);
    check("sof_eop_clks", sof_cnt, only ? 3 * div : 0);
    if (exp_oe >= 0) check("oe_clks", oe_cnt, exp_oe);
    if (exp_pre >= 0) check("bit_pulses_before_eop", pre_cnt, exp_pre);
    if (!only) decode_check(n);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [7:0] pkt11[11];
    rst         = 1'b0;
    tx_only_eop = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    usb_speed   = 1'b0;
    #5;
    check("reset_oe", usb_tx_oe, 0);
    check("reset_dpdm", int'({usb_tx_dp, usb_tx_dm}), 1);
    check("reset_ready", tx_ready, 0);
    check("reset_pulse", tx_bit_pulse, 0);
    check("reset_sof", is_sof_eop, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // LS single 0x00
    pkt[0] = 8'h00;
    run_pkt(1'b0, 1'b0, 1, 609, 1, 608, 16);

    // LS 11-byte descriptor packet
    pkt11 = '{8'h4B, 8'h12, 8'h01, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h08, 8'hAF, 8'hE0};
    foreach (pkt11[i]) pkt[i] = pkt11[i];
    run_pkt(1'b0, 1'b0, 11, 3169, 11, 3168, 96);

    // LS 0xFF: stuffed bit after bit 4
    pkt[0] = 8'hFF;
    run_pkt(1'b0, 1'b0, 1, 641, 1, 640, 17);

    // FS 0x00
    pkt[0] = 8'h00;
    run_pkt(1'b1, 1'b0, 1, FsSupported ? 77 : 609, 1, FsSupported ? 76 : 608, 16);

    // LS keep-alive EOP only
    run_pkt(1'b0, 1'b1, 0, 97, 0, 96, 0);

    // Reset mid-DATA
    @(negedge clk);
    usb_speed   = 1'b0;
    tx_only_eop = 1'b0;
    tx_data     = 8'h55;
    tx_valid    = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    tx_valid = 1'b0;
    #1;
    check("abort_oe", usb_tx_oe, 0);
    check("abort_dpdm", int'({usb_tx_dp, usb_tx_dm}), 1);
    check("abort_pulse", tx_bit_pulse, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    pkt[0] = 8'h00;
    run_pkt(1'b0, 1'b0, 1, 609, 1, 608, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
